// File: rtl/player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : player_move_ctrl
// Brief   : Direction-key arbiter (last-pressed wins) and speed power-up
//           level scheduler with per-level frame decay timer.
// Revision: 1.0 - initial release
// ============================================================================
module player_move_ctrl #(
    parameter int BOOST_FRAMES = 300,
    parameter int MAX_LEVEL    = 2,
    parameter int TIMER_W      = 10
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               game_on,
    input  logic               player_dead,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               speed_pickup,
    output logic               up_direction_key,
    output logic               down_direction_key,
    output logic               left_direction_key,
    output logic               right_direction_key,
    output logic [1:0]         speed_level,
    output logic [TIMER_W-1:0] boost_frames_left
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0]         c_max_level = 2'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] c_boost     = TIMER_W'(BOOST_FRAMES);

    state_t             r_state;
    logic [3:0]         r_key_d;
    logic [3:0]         r_last;        // one-hot {up,down,left,right}; 0 = NONE
    logic [1:0]         r_level;
    logic [TIMER_W-1:0] r_timer;

    logic [3:0]         w_keys;
    logic [3:0]         w_rise;
    logic [3:0]         w_last_nxt;
    logic [1:0]         w_level_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;

    assign w_keys = {key_up, key_down, key_left, key_right};
    assign w_rise = w_keys & ~r_key_d;

    function automatic logic [3:0] f_pick(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    always_comb begin
        w_last_nxt = 4'b0000;
        if (|w_rise)
            w_last_nxt = f_pick(w_rise);
        else if (|(r_last & w_keys))
            w_last_nxt = r_last;
        else
            w_last_nxt = f_pick(w_keys);
    end

    // Death beats pickup, pickup beats frame decay.
    always_comb begin
        w_level_nxt = r_level;
        w_timer_nxt = r_timer;
        if (player_dead) begin
            w_level_nxt = 2'd0;
            w_timer_nxt = '0;
        end else if (speed_pickup) begin
            w_level_nxt = (r_level >= c_max_level) ? c_max_level : r_level + 2'd1;
            w_timer_nxt = c_boost;
        end else if (startOfFrame && (r_level != 2'd0)) begin
            if (r_timer > TIMER_W'(1)) begin
                w_timer_nxt = r_timer - TIMER_W'(1);
            end else begin
                w_level_nxt = r_level - 2'd1;
                w_timer_nxt = (r_level > 2'd1) ? c_boost : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_key_d <= 4'b0000;
            r_last  <= 4'b0000;
            r_level <= 2'd0;
            r_timer <= '0;
        end else begin
            r_key_d <= w_keys;
            case (r_state)
                ST_IDLE: begin
                    r_last  <= 4'b0000;
                    r_level <= 2'd0;
                    r_timer <= '0;
                    if (game_on)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!game_on) begin
                        r_state <= ST_IDLE;
                        r_last  <= 4'b0000;
                        r_level <= 2'd0;
                        r_timer <= '0;
                    end else begin
                        r_last  <= w_last_nxt;
                        r_level <= w_level_nxt;
                        r_timer <= w_timer_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign up_direction_key    = r_last[3];
    assign down_direction_key  = r_last[2];
    assign left_direction_key  = r_last[1];
    assign right_direction_key = r_last[0];
    assign speed_level         = r_level;
    assign boost_frames_left   = r_timer;

endmodule
`default_nettype wire
